rf_wb_sched: RTL
================

# rf_wb_sched

Write-back scheduler and scoreboard for the 32×32 register file. Arbitrates up to NREQ producers (ALU, load unit, mul/div, …) onto the file's single write port (RF_W, destination address, write data) through one registered write-back stage. Tracks destinations with outstanding writes so issue logic can stall on RAW hazards against rs/rt. Sits between the execute/memory units and the register file, in the RF_CLK domain.

## Interface
- NREQ, 3: number of write-back requesters, 2..8
- DW, 32: data width
- AW, 5: register address width
- RF_CLK  in  1  clock; all state updates on rising edge
- RF_RST  in  1  reset; asynchronous, active-high
- req_valid  in  NREQ  requester i has a write pending
- req_addr  in  NREQ*AW  destination of requester i, slice [i*AW +: AW]
- req_data  in  NREQ*DW  data of requester i, slice [i*DW +: DW]
- req_ready  out  NREQ  one-hot grant; transfer when valid && ready
- rf_w  out  1  register file write enable
- rf_waddr  out  AW  register file write address
- rf_wdata  out  DW  register file write data
- issue_valid  in  1  decode issues an instruction writing issue_addr
- issue_addr  in  AW  destination of the issuing instruction
- issue_stall  out  1  issue_addr already pending; issue ignored
- rs_addr, rt_addr  in  AW each  source addresses queried by decode
- rs_busy, rt_busy  out  1 each  queried register has a pending write
- wb_count  out  16  committed non-zero-address writes, saturating

## Operation
- Grant: among asserted req_valid, one bit of req_ready set combinationally in the same cycle; req_ready all-zero when no requests. A granted request is always accepted; the write-back stage never backpressures.
- Write-back stage: on a transfer, register wb_valid=1, wb_addr, wb_data; otherwise wb_valid=0. rf_w = wb_valid && wb_addr!=0; rf_waddr=wb_addr; rf_wdata=wb_data.
- Address 0: accepted and consumed, rf_w stays 0, wb_count unchanged.
- Scoreboard: 32-bit pending vector, bit 0 hard-wired 0.
  - Set pending[issue_addr] when issue_valid && !issue_stall && issue_addr!=0.
  - Clear pending[wb_addr] at the edge ending a cycle with wb_valid.
  - Set and clear of the same bit in one cycle: set wins.
- issue_stall = pending[issue_addr] (combinational); 0 for address 0.
- rs_busy = pending[rs_addr], rt_busy = pending[rt_addr], combinational. A register being written in the current cycle (rf_w, rf_waddr match) still reports busy.
- wb_count increments by 1 per rf_w cycle; holds at 16'hFFFF.

## Timing
- Latency: request accepted in cycle N → rf_w high in cycle N+1; the register file captures on the rising edge ending N+1.
- pending bit drops the cycle after rf_w; a dependent instruction may issue in cycle N+2.
- Throughput: one write per cycle, sustained.
- Reset values: rf_w=0, rf_waddr=0, rf_wdata=0, wb_valid=0, pending=0, wb_count=0, round-robin pointer=NREQ-1, so requester 0 has priority after reset. req_ready, issue_stall, rs_busy, rt_busy evaluate to 0 under reset.
- Reset mid-operation: an in-flight write-back is dropped without asserting rf_w. Requesters must re-present requests.

## Configuration
- RF_WB_RR_EN defined: round-robin arbitration. A pointer holds the last granted index and updates only on a transfer. Search starts at pointer+1 mod NREQ. No requester waits more than NREQ-1 grants.
- RF_WB_RR_EN undefined: fixed priority, lowest index wins. Pointer register not built.

## Structure
- Shared package rf_pkg: RF_AW=5, RF_DW=32, RF_NREGS=32, RF_ZERO_ADDR=0, and typedef rf_addr_t for the 5-bit address.
- One sub-module, rf_wb_arb: NREQ-wide grant logic with the optional round-robin pointer. Scoreboard, write-back stage and counter are in the top module.

## Test plan
- Single request: req_valid=3'b001, addr=5, data=32'hDEADBEEF in cycle 0 → req_ready=001 in cycle 0; rf_w=1, rf_waddr=5, rf_wdata=DEADBEEF in cycle 1; wb_count=1.
- Contention, RR on: all three valid for 6 cycles → grants 0,1,2,0,1,2. RR off → grant 0 in every cycle.
- Zero address: requester 1 writes addr 0, data 32'h1234 → accepted, rf_w stays 0, wb_count unchanged.
- Scoreboard: issue addr 9 → rs_busy=1 for rs_addr=9. A second issue of 9 → issue_stall=1 and no state change. Write-back of 9 → rs_busy=0 the cycle after rf_w.
- Same-cycle set/clear: wb of addr 7 coincides with issue of addr 7 → pending[7] remains 1.
- Async reset during an accepted transfer → rf_w never asserts, pending=0, wb_count=0, and requester 0 gets the next grant.

Source files
------------

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file constants and address type
package rf_pkg;

    localparam int RF_AW     = 5;
    localparam int RF_DW     = 32;
    localparam int RF_NREGS  = 32;

    typedef logic [RF_AW-1:0] rf_addr_t;

    localparam rf_addr_t RF_ZERO_ADDR = '0;

endpackage

// File: rtl/rf_wb_arb.sv
// rtl/rf_wb_arb.sv - NREQ-wide one-hot write-back grant logic
//
// Ports: RF_CLK/RF_RST (pointer state only), req_valid (requests), grant (one-hot,
// combinational, all-zero when no requests).
// Build option RF_WB_RR_EN: round-robin with a last-grant pointer; otherwise
// fixed priority with the lowest index winning and no state.
module rf_wb_arb #(
    parameter int NREQ = 3
) (
    input  logic            RF_CLK,
    input  logic            RF_RST,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] grant
);

`ifdef RF_WB_RR_EN
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0] ptr;
    logic          found;
    int            idx;

    // Search starts one past the last winner so every requester is reached
    // within NREQ-1 grants to others.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    // Any grant is a transfer, since the write-back stage never stalls.
    always_ff @(posedge RF_CLK or posedge RF_RST) begin
        if (RF_RST) begin
            ptr <= PW'(NREQ - 1);
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i]) begin
                    ptr <= PW'(i);
                end
            end
        end
    end
`else
    logic found;
    logic unused_clk_rst;

    assign unused_clk_rst = RF_CLK ^ RF_RST;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/rf_wb_sched.sv
// rtl/rf_wb_sched.sv - register-file write-back scheduler and RAW scoreboard
//
// Ports: RF_CLK, RF_RST (async, active-high); req_valid/req_addr/req_data from
// NREQ producers with one-hot req_ready; rf_w/rf_waddr/rf_wdata to the register
// file write port; issue_valid/issue_addr with issue_stall; rs_addr/rt_addr
// with rs_busy/rt_busy; wb_count (saturating committed-write count).
// Build option RF_WB_RR_EN selects round-robin arbitration in rf_wb_arb.
module rf_wb_sched
    import rf_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int DW   = RF_DW,
    parameter int AW   = RF_AW
) (
    input  logic               RF_CLK,
    input  logic               RF_RST,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               rf_w,
    output logic [AW-1:0]      rf_waddr,
    output logic [DW-1:0]      rf_wdata,
    input  logic               issue_valid,
    input  logic [AW-1:0]      issue_addr,
    output logic               issue_stall,
    input  logic [AW-1:0]      rs_addr,
    input  logic [AW-1:0]      rt_addr,
    output logic               rs_busy,
    output logic               rt_busy,
    output logic [15:0]        wb_count
);

    logic [NREQ-1:0]     grant;
    logic                xfer;
    logic [AW-1:0]       sel_addr;
    logic [DW-1:0]       sel_data;
    logic                wb_valid;
    logic [AW-1:0]       wb_addr;
    logic [DW-1:0]       wb_data;
    logic [RF_NREGS-1:0] pending;
    logic [RF_NREGS-1:0] pending_nxt;
    logic                issue_acc;

    rf_wb_arb #(.NREQ(NREQ)) u_arb (
        .RF_CLK    (RF_CLK),
        .RF_RST    (RF_RST),
        .req_valid (req_valid),
        .grant     (grant)
    );

    assign req_ready = RF_RST ? '0 : grant;
    assign xfer      = |req_ready;

    // Grant is one-hot, so OR-ing the masked slices selects the winner.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_addr = sel_addr | req_addr[i*AW +: AW];
                sel_data = sel_data | req_data[i*DW +: DW];
            end
        end
    end

    assign rf_w     = wb_valid && (wb_addr != AW'(RF_ZERO_ADDR));
    assign rf_waddr = wb_addr;
    assign rf_wdata = wb_data;

    assign issue_stall = !RF_RST && (issue_addr != AW'(RF_ZERO_ADDR)) && pending[issue_addr];
    assign rs_busy     = !RF_RST && pending[rs_addr];
    assign rt_busy     = !RF_RST && pending[rt_addr];
    assign issue_acc   = issue_valid && !issue_stall && (issue_addr != AW'(RF_ZERO_ADDR));

    // Clear is applied before set so a same-cycle issue to the register being
    // written back keeps it pending for the new producer.
    always_comb begin
        pending_nxt = pending;
        if (wb_valid) begin
            pending_nxt[wb_addr] = 1'b0;
        end
        if (issue_acc) begin
            pending_nxt[issue_addr] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge RF_CLK or posedge RF_RST) begin
        if (RF_RST) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            pending  <= '0;
            wb_count <= '0;
        end else begin
            wb_valid <= xfer;
            if (xfer) begin
                wb_addr <= sel_addr;
                wb_data <= sel_data;
            end
            pending <= pending_nxt;
            if (rf_w && (wb_count != 16'hFFFF)) begin
                wb_count <= wb_count + 16'd1;
            end
        end
    end

endmodule
